acs_scheduler: RTL and testbench

Sequencer for the Viterbi add-compare-select stage of the LRPT decoder (K=7, 64 states, single shared ACS lane). The block initialises the ping-pong state-metric RAM and accepts one branch-metric step per handshake. For each of the 64 destination states it issues predecessor addresses to the butterfly datapath, writes the normalised results back to the opposite bank, and packs the decision bits into one survivor word per step for the traceback unit.

---
 rtl/viterbi_pkg.sv | 12 +
 rtl/sm_normaliser.sv | 31 +++
 rtl/acs_scheduler.sv | 114 +++++++++++
 tb/tb_acs_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants, scheduler states and ACS helpers for the LRPT Viterbi stage
package viterbi_pkg;
  localparam int NUM_STATES = 64;
  localparam int STATE_W = 6;
  typedef enum logic [2:0] {INIT, IDLE, ISSUE, DRAIN, COMMIT} sched_state_t;
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : '0;
  endfunction
  function automatic logic [STATE_W-1:0] pred_state(input logic [STATE_W-1:0] dst, input logic b);
    return {dst[STATE_W-2:0], b};
  endfunction
endpackage

// File: rtl/sm_normaliser.sv
// sm_normaliser: subtracts the current step norm from ACS metrics, tracks the step minimum
// and latches the next norm when that minimum crosses the threshold.
module sm_normaliser import viterbi_pkg::*; #(
  parameter int SM_W = 20,
  parameter logic [SM_W-1:0] NORM_THRESH = 20'h80000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            upd_i,
  input  logic            commit_i,
  input  logic [SM_W-1:0] acs_sm_i,
  output logic [SM_W-1:0] wr_data_o,
  output logic            norm_applied_o
);
  logic [SM_W-1:0] min_q, min_d, norm_q, norm_d;
  assign wr_data_o = SM_W'(sat_sub(32'(acs_sm_i), 32'(norm_q)));
  always_comb begin
    min_d = clear_i ? '1 : (upd_i && wr_data_o < min_q) ? wr_data_o : min_q;
    norm_d = commit_i ? ((min_q >= NORM_THRESH) ? min_q : '0) : norm_q;
  end
  assign norm_applied_o = commit_i && norm_d != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      min_q <= '1;
      norm_q <= '0;
    end else begin
      min_q <= min_d;
      norm_q <= norm_d;
    end
endmodule

// File: rtl/acs_scheduler.sv
// acs_scheduler: sequences the shared ACS lane over 64 destination states per step,
// ping-pongs the metric RAM banks and packs decisions into one survivor word per step.
module acs_scheduler import viterbi_pkg::*; #(
  parameter int SM_W = 20,
  parameter logic [SM_W-1:0] INIT_MET = 20'd4096,
  parameter logic [SM_W-1:0] NORM_THRESH = 20'h80000
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  output logic                  busy,
  output logic                  acs_issue_valid,
  output logic [STATE_W-1:0]    acs_dst,
  output logic [STATE_W-1:0]    acs_src0,
  output logic [STATE_W-1:0]    acs_src1,
  output logic                  sm_rd_bank,
  input  logic                  acs_valid,
  input  logic [SM_W-1:0]       acs_sm,
  input  logic                  acs_desc,
  output logic                  sm_wr_en,
  output logic                  sm_wr_bank,
  output logic [STATE_W-1:0]    sm_wr_addr,
  output logic [SM_W-1:0]       sm_wr_data,
  output logic                  surv_valid,
  input  logic                  surv_ready,
  output logic [NUM_STATES-1:0] surv_word,
  output logic                  norm_applied,
  output logic                  err_unexp
);
  sched_state_t state_q, state_d;
  logic [STATE_W-1:0] cnt_q, cnt_d;
  logic [STATE_W:0] ret_q, ret_d;
  logic [NUM_STATES-1:0] shadow_q, shadow_d;
  logic bank_q, bank_d, err_q, err_d, go_q;
  logic ret_ok, init_wr, sym_fire, surv_fire;
  logic [SM_W-1:0] norm_data;
  // go_q holds INIT writes off until the first clock after reset release
  assign init_wr = state_q == INIT && go_q;
  assign ret_ok = acs_valid && (state_q == ISSUE || state_q == DRAIN) && !ret_q[STATE_W];
  assign sym_fire = sym_valid && state_q == IDLE;
  assign surv_fire = surv_ready && state_q == COMMIT;
  assign sym_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign acs_issue_valid = state_q == ISSUE;
  assign acs_dst = cnt_q;
  assign acs_src0 = pred_state(cnt_q, 1'b0);
  assign acs_src1 = pred_state(cnt_q, 1'b1);
  assign sm_rd_bank = bank_q;
  assign sm_wr_en = init_wr || ret_ok;
  assign sm_wr_bank = state_q != INIT && !bank_q;
  assign sm_wr_addr = state_q == INIT ? cnt_q : ret_q[STATE_W-1:0];
  assign sm_wr_data = state_q == INIT ? (cnt_q == '0 ? '0 : INIT_MET) : norm_data;
  assign surv_valid = state_q == COMMIT;
  assign surv_word = shadow_q;
  assign err_unexp = err_q;
  sm_normaliser #(.SM_W(SM_W), .NORM_THRESH(NORM_THRESH)) u_norm (
    .clk(clk), .rst_n(sys_rst_n), .clear_i(sym_fire), .upd_i(ret_ok), .commit_i(surv_fire),
    .acs_sm_i(acs_sm), .wr_data_o(norm_data), .norm_applied_o(norm_applied)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ret_d = ret_q + {{STATE_W{1'b0}}, ret_ok};
    bank_d = bank_q;
    shadow_d = shadow_q;
    if (ret_ok) shadow_d[ret_q[STATE_W-1:0]] = acs_desc;
    err_d = err_q || (acs_valid && !ret_ok);
    case (state_q)
      INIT: if (go_q) begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
          bank_d = 1'b0;
        end
      end
      IDLE: if (sym_valid) begin
        state_d = ISSUE;
        cnt_d = '0;
        ret_d = '0;
        shadow_d = '0;
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = &cnt_q ? DRAIN : ISSUE;
      end
      // leaving on the 64th return itself keeps the step at the minimum cycle count
      DRAIN: state_d = ret_d[STATE_W] ? COMMIT : DRAIN;
      COMMIT: if (surv_ready) begin
        state_d = IDLE;
        bank_d = !bank_q;
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      ret_q <= '0;
      bank_q <= 1'b0;
      shadow_q <= '0;
      err_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ret_q <= ret_d;
      bank_q <= bank_d;
      shadow_q <= shadow_d;
      err_q <= err_d;
      go_q <= 1'b1;
    end
endmodule

// File: tb/tb_acs_scheduler.sv
// tb_acs_scheduler: table-driven and randomized checks of acs_scheduler against a step-level model
module tb_acs_scheduler;
  localparam int ACS_LAT = 2;
  localparam logic [19:0] THRESH = 20'h80000;
  logic clk = 1'b0, sys_rst_n = 1'b0, sym_valid = 1'b0, acs_valid = 1'b0, acs_desc = 1'b0, surv_ready = 1'b0;
  logic [19:0] acs_sm = '0;
  logic sym_ready, busy, acs_issue_valid, sm_rd_bank, sm_wr_en, sm_wr_bank, surv_valid, norm_applied, err_unexp;
  logic [5:0] acs_dst, acs_src0, acs_src1, sm_wr_addr;
  logic [19:0] sm_wr_data;
  logic [63:0] surv_word;
  int checks = 0, errors = 0;
  logic [19:0] stim_sm [64];
  logic stim_desc [64];
  logic [19:0] model_norm = '0, got_wr0, got_wr63;
  logic exp_bank = 1'b0, exp_err = 1'b0, got_applied;
  logic [63:0] got_word;

  acs_scheduler dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready), .busy(busy),
    .acs_issue_valid(acs_issue_valid), .acs_dst(acs_dst), .acs_src0(acs_src0), .acs_src1(acs_src1),
    .sm_rd_bank(sm_rd_bank), .acs_valid(acs_valid), .acs_sm(acs_sm), .acs_desc(acs_desc),
    .sm_wr_en(sm_wr_en), .sm_wr_bank(sm_wr_bank), .sm_wr_addr(sm_wr_addr), .sm_wr_data(sm_wr_data),
    .surv_valid(surv_valid), .surv_ready(surv_ready), .surv_word(surv_word),
    .norm_applied(norm_applied), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic init_check();
    int nw = 0, rdy_at = -1;
    for (int i = 0; i < 80 && rdy_at < 0; i++) begin
      @(negedge clk);
      if (sm_wr_en) begin
        chk("init_addr", 64'(sm_wr_addr), 64'(nw));
        chk("init_bank", 64'(sm_wr_bank), 64'(0));
        chk("init_data", 64'(sm_wr_data), nw == 0 ? 64'(0) : 64'(4096));
        nw++;
      end
      if (sym_ready) rdy_at = i;
    end
    chk("init_writes", 64'(nw), 64'(64));
    chk("init_ready_cycle", 64'(rdy_at), 64'(65));
    chk("init_err", 64'(err_unexp), 64'(0));
    exp_bank = 1'b0;
    model_norm = '0;
    exp_err = 1'b0;
  endtask

  task automatic run_step(input int hold, input int rst_at);
    int cyc = 0, ni = 0, nw = 0, seen = 0, acc = -1, first = -1;
    int due[$];
    int dq[$];
    logic rdy_prev, done = 1'b0;
    logic [63:0] w0 = '0, exp_word;
    logic [19:0] wmin = '1, e;
    for (int k = 0; k < 64; k++) exp_word[k] = stim_desc[k];
    sym_valid = 1'b1;
    rdy_prev = sym_ready;
    for (int t = 0; t < 300 && !done; t++) begin
      @(posedge clk); #1;
      cyc++;
      if (sym_valid && rdy_prev) begin
        sym_valid = 1'b0;
        acc = cyc;
      end
      acs_valid = 1'b0;
      if (due.size() > 0 && due[0] == cyc) begin
        acs_valid = 1'b1;
        acs_sm = stim_sm[dq[0]];
        acs_desc = stim_desc[dq[0]];
        void'(due.pop_front());
        void'(dq.pop_front());
      end
      surv_ready = seen >= hold;
      @(negedge clk);
      rdy_prev = sym_ready;
      if (acs_issue_valid) begin
        chk("issue_dst", 64'(acs_dst), 64'(ni));
        chk("issue_src0", 64'(acs_src0), 64'((ni * 2) % 64));
        chk("issue_src1", 64'(acs_src1), 64'((ni * 2) % 64 + 1));
        chk("issue_rd_bank", 64'(sm_rd_bank), 64'(exp_bank));
        due.push_back(cyc + ACS_LAT);
        dq.push_back(ni);
        if (ni == rst_at) begin
          sys_rst_n = 1'b0;
          acs_valid = 1'b0;
          #1;
          chk("reset_strobes", 64'({acs_issue_valid, sm_wr_en, surv_valid, sym_ready, norm_applied, err_unexp, busy}), 64'(7'b0000001));
          chk("reset_surv_word", surv_word, 64'(0));
          chk("reset_rd_bank", 64'(sm_rd_bank), 64'(0));
          return;
        end
        ni++;
      end
      if (sm_wr_en) begin
        if (nw < 64) begin
          e = stim_sm[nw] > model_norm ? stim_sm[nw] - model_norm : 20'd0;
          chk("wr_addr", 64'(sm_wr_addr), 64'(nw));
          chk("wr_bank", 64'(sm_wr_bank), 64'(!exp_bank));
          chk("wr_data", 64'(sm_wr_data), 64'(e));
          if (nw == 0) got_wr0 = sm_wr_data;
          if (nw == 63) got_wr63 = sm_wr_data;
          if (e < wmin) wmin = e;
        end else chk("extra_write", 64'(nw), 64'(63));
        nw++;
      end
      if (surv_valid) begin
        if (seen == 0) begin
          first = cyc;
          w0 = surv_word;
        end else begin
          chk("surv_stable", surv_word, w0);
          chk("commit_sym_ready", 64'(sym_ready), 64'(0));
        end
        if (!surv_ready) chk("norm_pulse_held", 64'(norm_applied), 64'(0));
        seen++;
        if (surv_ready) begin
          done = 1'b1;
          got_word = surv_word;
          got_applied = norm_applied;
        end
      end
    end
    if (!done) chk("step_timeout", 64'(0), 64'(1));
    chk("surv_word", got_word, exp_word);
    chk("norm_applied", 64'(got_applied), 64'(wmin >= THRESH));
    chk("step_writes", 64'(nw), 64'(64));
    chk("step_issues", 64'(ni), 64'(64));
    chk("commit_latency", 64'(first - acc), 64'(66));
    chk("step_err", 64'(err_unexp), 64'(exp_err));
    model_norm = wmin >= THRESH ? wmin : 20'd0;
    exp_bank = !exp_bank;
    @(negedge clk);
    chk("ready_after_commit", 64'(sym_ready), 64'(1));
    chk("bank_toggle", 64'(sm_rd_bank), 64'(exp_bank));
  endtask

  task automatic rand_stim();
    logic [19:0] base;
    base = $urandom_range(0, 1) ? 20'h88000 : 20'h00800;
    for (int k = 0; k < 64; k++) begin
      stim_sm[k] = base + 20'($urandom_range(0, 20'hFFFF));
      stim_desc[k] = 1'($urandom_range(0, 1));
    end
  endtask

  typedef struct {
    int mode;
    logic [19:0] base;
    int desc_mode;
    int hold;
    logic [19:0] e0;
    logic [19:0] e63;
    logic app;
    logic [63:0] word;
  } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{0, 20'd100, 0, 0, 20'd100, 20'd163, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
    tbl[1] = '{0, 20'd100, 0, 10, 20'd100, 20'd163, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
    tbl[2] = '{1, 20'h90000, 1, 0, 20'h90000, 20'h90000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{1, 20'h90010, 2, 0, 20'h00010, 20'h00010, 1'b0, 64'h0};
    tbl[4] = '{1, 20'h90000, 0, 1, 20'h90000, 20'h90000, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA};
    tbl[5] = '{0, 20'h00010, 1, 0, 20'h0, 20'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    repeat (3) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    init_check();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 64; k++) begin
        stim_sm[k] = tbl[i].mode == 0 ? tbl[i].base + 20'(k) : tbl[i].base;
        stim_desc[k] = tbl[i].desc_mode == 0 ? 1'(k & 1) : tbl[i].desc_mode == 1;
      end
      run_step(tbl[i].hold, -1);
      chk($sformatf("tbl%0d_wr0", i), 64'(got_wr0), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_wr63", i), 64'(got_wr63), 64'(tbl[i].e63));
      chk($sformatf("tbl%0d_applied", i), 64'(got_applied), 64'(tbl[i].app));
      chk($sformatf("tbl%0d_word", i), got_word, tbl[i].word);
    end
    for (int r = 0; r < 6; r++) begin
      rand_stim();
      run_step($urandom_range(0, 3), -1);
    end
    acs_valid = 1'b1;
    acs_sm = 20'h5;
    #1;
    chk("spur_no_write", 64'(sm_wr_en), 64'(0));
    @(posedge clk); #1;
    acs_valid = 1'b0;
    @(negedge clk);
    chk("spur_err", 64'(err_unexp), 64'(1));
    exp_err = 1'b1;
    rand_stim();
    run_step(0, -1);
    rand_stim();
    run_step(0, 30);
    repeat (3) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    init_check();
    rand_stim();
    run_step(2, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end
endmodule
